// File: rtl/fc_error_gen.sv
// fc_error_gen: streams per-class signed errors (score - target) for one sample over valid/ready.
// Optional macro ERR_ACCUM_EN adds a loss port accumulating |error| over the sample.
module fc_error_gen #(
    parameter int CLASSIFICATIONS = 10,
    parameter int NORMALIZED_SIZE = 25,
    parameter logic [NORMALIZED_SIZE-1:0] TARGET_VALUE = {NORMALIZED_SIZE{1'b1}},
    localparam int ERROR_SIZE = NORMALIZED_SIZE + 1
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start,
    input  logic [CLASSIFICATIONS*NORMALIZED_SIZE-1:0]   normalized_results,
    input  logic [CLASSIFICATIONS-1:0]                   class_hotcoded,
    input  logic [CLASSIFICATIONS-1:0]                   label_hotcoded,
    output logic                                         err_valid,
    input  logic                                         err_ready,
    output logic signed [ERROR_SIZE-1:0]                 err_data,
    output logic [4:0]                                   err_index,
    output logic                                         err_last,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         correct,
`ifdef ERR_ACCUM_EN
    output logic [NORMALIZED_SIZE+$clog2(CLASSIFICATIONS)-1:0] loss,
`endif
    output logic                                         label_err
);
    localparam int C  = CLASSIFICATIONS;
    localparam int N  = NORMALIZED_SIZE;
    localparam int IW = $clog2(C);

    typedef enum logic [1:0] {IDLE, CAPTURE, STREAM, DONE} state_t;
    state_t state, state_nxt;
    logic [N-1:0] sc_q [C];
    logic [C-1:0] cls_q, lbl_q;
    logic [IW-1:0] idx;
    logic one_hot, last_i, fire;
    logic signed [ERROR_SIZE-1:0] err;

    assign one_hot = (lbl_q != '0) && ((lbl_q & (lbl_q - C'(1))) == '0);
    assign last_i  = idx == IW'(C - 1);
    assign fire    = (state == STREAM) && err_ready;
    assign err     = $signed({1'b0, sc_q[idx]}) - $signed({1'b0, lbl_q[idx] ? TARGET_VALUE : N'(0)});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? CAPTURE : IDLE;
            CAPTURE: state_nxt = one_hot ? STREAM : DONE;
            STREAM:  state_nxt = (err_ready && last_i) ? DONE : STREAM;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        err_valid = state == STREAM;
        busy      = state != IDLE;
        done      = state == DONE;
        err_last  = err_valid && last_i;
        err_index = err_valid ? 5'(idx) : 5'd0;
        err_data  = err_valid ? err : '0;
    end

`ifdef ERR_ACCUM_EN
    // magnitude of an N+1-bit signed difference of two N-bit values always fits in N bits
    logic [N-1:0] mag;
    assign mag = err[ERROR_SIZE-1] ? N'(-err) : N'(err);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            loss <= '0;
        else if (state == IDLE && start)
            loss <= '0;
        else if (fire)
            loss <= loss + $bits(loss)'(mag);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C; i++) sc_q[i] <= '0;
            cls_q     <= '0;
            lbl_q     <= '0;
            idx       <= '0;
            correct   <= 1'b0;
            label_err <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                for (int i = 0; i < C; i++) sc_q[i] <= normalized_results[i*N +: N];
                cls_q     <= class_hotcoded;
                lbl_q     <= label_hotcoded;
                correct   <= 1'b0;
                label_err <= 1'b0;
            end
            if (state == CAPTURE) begin
                correct   <= cls_q == lbl_q;
                label_err <= !one_hot;
                idx       <= '0;
            end
            if (fire)
                idx <= last_i ? '0 : idx + IW'(1);
        end
    end
endmodule

// File: tb/tb_fc_error_gen.sv
// tb_fc_error_gen: directed self-checking bench for fc_error_gen; drives and samples on the falling edge.
module tb_fc_error_gen;
    localparam int C = 10;
    localparam int N = 25;
    localparam int E = 26;

    logic clk = 0, rst_n = 0, start = 0, err_ready = 0;
    logic [C*N-1:0] normalized_results = '0;
    logic [C-1:0] class_hotcoded = '0, label_hotcoded = '0;
    logic err_valid, err_last, busy, done, correct, label_err;
    logic signed [E-1:0] err_data;
    logic [4:0] err_index;
`ifdef ERR_ACCUM_EN
    logic [28:0] loss;
`endif
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    fc_error_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .normalized_results(normalized_results),
        .class_hotcoded(class_hotcoded), .label_hotcoded(label_hotcoded),
        .err_valid(err_valid), .err_ready(err_ready), .err_data(err_data),
        .err_index(err_index), .err_last(err_last), .busy(busy), .done(done),
        .correct(correct),
`ifdef ERR_ACCUM_EN
        .loss(loss),
`endif
        .label_err(label_err)
    );

    task automatic set_score(input int i, input logic [N-1:0] v);
        normalized_results[i*N +: N] = v;
    endtask

    task automatic load_case2();
        normalized_results = '0;
        set_score(5, 25'h100);
        label_hotcoded = 10'b0000000001;
        class_hotcoded = 10'b0000100000;
    endtask

    task automatic test_reset();
        rst_n = 0;
        @(negedge clk);
        checks++;
        if ({err_valid, busy, done, correct, label_err, err_last} !== 6'b0 || err_index !== 5'd0 || err_data !== 26'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b idx=%0d data=%h exp=0", {err_valid, busy, done, correct, label_err, err_last}, err_index, err_data);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_match();
        normalized_results = '0;
        set_score(3, 25'h1FFFFFF);
        label_hotcoded = 10'b0000001000;
        class_hotcoded = 10'b0000001000;
        err_ready = 1;
        start = 1;
        @(negedge clk);
        normalized_results = '1;
        checks++;
        if (busy !== 1'b1 || err_valid !== 1'b0) begin
            failures++;
            $display("FAIL match_capture busy=%b valid=%b exp busy=1 valid=0", busy, err_valid);
        end
        @(negedge clk);
        for (int k = 0; k < C; k++) begin
            if (k == 4) start = 0;
            checks++;
            if (err_valid !== 1'b1 || err_index !== 5'(k) || err_data !== 26'd0 || err_last !== (k == C - 1)) begin
                failures++;
                $display("FAIL match_beat%0d valid=%b idx=%0d data=%h last=%b exp idx=%0d data=0", k, err_valid, err_index, err_data, err_last, k);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || correct !== 1'b1 || label_err !== 1'b0 || err_valid !== 1'b0) begin
            failures++;
            $display("FAIL match_done done=%b correct=%b label_err=%b valid=%b exp 1 1 0 0", done, correct, label_err, err_valid);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || correct !== 1'b1) begin
            failures++;
            $display("FAIL match_idle busy=%b done=%b correct=%b exp 0 0 1", busy, done, correct);
        end
    endtask

    task automatic test_mismatch();
        logic [E-1:0] exp_d;
        load_case2();
        err_ready = 1;
        start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        for (int k = 0; k < C; k++) begin
            exp_d = (k == 0) ? 26'h2000001 : (k == 5) ? 26'h0000100 : 26'h0;
            checks++;
            if (err_valid !== 1'b1 || err_index !== 5'(k) || err_data !== exp_d) begin
                failures++;
                $display("FAIL mismatch_beat%0d valid=%b idx=%0d data=%h exp data=%h", k, err_valid, err_index, err_data, exp_d);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || correct !== 1'b0 || label_err !== 1'b0) begin
            failures++;
            $display("FAIL mismatch_done done=%b correct=%b label_err=%b exp 1 0 0", done, correct, label_err);
        end
        @(negedge clk);
    endtask

    task automatic test_label_err();
        logic [C-1:0] lbls [2];
        logic [C-1:0] clss [2];
        logic exp_c [2];
        lbls[0] = 10'b0000000011; clss[0] = 10'b0000000001; exp_c[0] = 1'b0;
        lbls[1] = 10'b0000000000; clss[1] = 10'b0000000000; exp_c[1] = 1'b1;
        for (int v = 0; v < 2; v++) begin
            label_hotcoded = lbls[v];
            class_hotcoded = clss[v];
            start = 1;
            @(negedge clk);
            start = 0;
            checks++;
            if (err_valid !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL label_err%0d_capture valid=%b busy=%b exp 0 1", v, err_valid, busy);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || label_err !== 1'b1 || err_valid !== 1'b0 || correct !== exp_c[v]) begin
                failures++;
                $display("FAIL label_err%0d_done done=%b label_err=%b valid=%b correct=%b exp 1 1 0 %b", v, done, label_err, err_valid, correct, exp_c[v]);
            end
            @(negedge clk);
            checks++;
            if (label_err !== 1'b1 || busy !== 1'b0 || err_valid !== 1'b0) begin
                failures++;
                $display("FAIL label_err%0d_hold label_err=%b busy=%b valid=%b exp 1 0 0", v, label_err, busy, err_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [E-1:0] exp_d;
        int k;
        normalized_results = '0;
        for (int i = 0; i < C; i++) set_score(i, 25'(i * 'h11));
        label_hotcoded = 10'b1000000000;
        class_hotcoded = 10'b1000000000;
        err_ready = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        k = 0;
        for (int t = 0; t < 40 && k < C; t++) begin
            err_ready = (t % 2 == 0);
            exp_d = (k == 9) ? 26'h200009A : E'(k * 'h11);
            checks++;
            if (err_valid !== 1'b1 || err_index !== 5'(k) || err_data !== exp_d || err_last !== (k == C - 1)) begin
                failures++;
                $display("FAIL bp_t%0d valid=%b idx=%0d data=%h last=%b exp idx=%0d data=%h", t, err_valid, err_index, err_data, err_last, k, exp_d);
            end
            if (err_ready) k++;
            @(negedge clk);
        end
        err_ready = 1;
        checks++;
        if (k != C || done !== 1'b1 || correct !== 1'b1) begin
            failures++;
            $display("FAIL bp_done beats=%0d done=%b correct=%b exp 10 1 1", k, done, correct);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        load_case2();
        err_ready = 1;
        start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if (err_index !== 5'd4 || err_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_beat4 idx=%0d valid=%b exp 4 1", err_index, err_valid);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (err_valid !== 1'b0 || busy !== 1'b0 || err_index !== 5'd0 || err_data !== 26'd0 || err_last !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async valid=%b busy=%b idx=%0d data=%h exp all 0", err_valid, busy, err_index, err_data);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (err_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_residual valid=%b busy=%b done=%b exp 0 0 0", err_valid, busy, done);
        end
        start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        checks++;
        if (err_valid !== 1'b1 || err_index !== 5'd0 || err_data !== 26'h2000001) begin
            failures++;
            $display("FAIL rstmid_fresh valid=%b idx=%0d data=%h exp 1 0 2000001", err_valid, err_index, err_data);
        end
        for (int t = 0; t < 20 && done !== 1'b1; t++) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_drain done=%b exp 1", done);
        end
        @(negedge clk);
    endtask

`ifdef ERR_ACCUM_EN
    task automatic test_accum();
        load_case2();
        err_ready = 1;
        start = 1;
        @(negedge clk);
        start = 0;
        checks++;
        if (loss !== 29'd0) begin
            failures++;
            $display("FAIL accum_clear loss=%h exp 0", loss);
        end
        for (int t = 0; t < 20 && done !== 1'b1; t++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || loss !== 29'h20000FF) begin
            failures++;
            $display("FAIL accum_done done=%b loss=%h exp 1 20000FF", done, loss);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_label_err();
        test_backpressure();
        test_reset_mid();
`ifdef ERR_ACCUM_EN
        test_accum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
